// File: rtl/wb_stage_if.sv
// MEM -> WB bundle and the register-file write port of wb_stage.
// The MEM side uses the master modport and wb_stage uses the slave modport.
interface wb_stage_if;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_pc;
  logic [31:0] i_alu_data;
  logic [31:0] i_ld_data;
  logic [1:0]  i_addr_lsb;
  logic [2:0]  i_funct3;
  logic [1:0]  i_wb_sel;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren;

  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic        o_valid;
  logic [31:0] o_pc;
  logic        o_ld_misalign;
  logic [63:0] o_instret;

  modport master (
    output i_valid, i_stall, i_flush, i_pc, i_alu_data, i_ld_data, i_addr_lsb,
           i_funct3, i_wb_sel, i_rd_addr, i_rd_wren,
    input  o_rd_addr, o_rd_data, o_rd_wren, o_valid, o_pc, o_ld_misalign, o_instret
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_pc, i_alu_data, i_ld_data, i_addr_lsb,
           i_funct3, i_wb_sel, i_rd_addr, i_rd_wren,
    output o_rd_addr, o_rd_data, o_rd_wren, o_valid, o_pc, o_ld_misalign, o_instret
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load formatting and write-back source select.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter on o_instret.
module wb_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  wb_stage_if.slave  bus
);

  // Handshake: i_valid qualifies the MEM bundle and there is no ready; the
  // upstream stage freezes this register with i_stall and squashes the
  // instruction being captured with i_flush (flush beats stall).
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] wb_data;
  logic            misalign;
  logic            capture;

  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rd_data_q;
  logic            rd_wren_q;
  logic            valid_q;
  logic [31:0]     pc_q;
  logic            misalign_q;

  assign capture = !bus.i_flush && !bus.i_stall;

  always_comb begin
    sel_byte = bus.i_ld_data[7:0];
    case (bus.i_addr_lsb)
      2'd1:    sel_byte = bus.i_ld_data[15:8];
      2'd2:    sel_byte = bus.i_ld_data[23:16];
      2'd3:    sel_byte = bus.i_ld_data[31:24];
      default: sel_byte = bus.i_ld_data[7:0];
    endcase
    sel_half = bus.i_addr_lsb[1] ? bus.i_ld_data[31:16] : bus.i_ld_data[15:0];

    ld_fmt = '0;
    case (bus.i_funct3)
      3'b000:  ld_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ld_fmt = {{16{sel_half[15]}}, sel_half};
      3'b010:  ld_fmt = bus.i_ld_data;
      3'b100:  ld_fmt = {24'h0, sel_byte};
      3'b101:  ld_fmt = {16'h0, sel_half};
      default: ld_fmt = '0;
    endcase

    misalign = 1'b0;
    if (bus.i_valid && bus.i_wb_sel == 2'b01) begin
      case (bus.i_funct3)
        3'b001, 3'b101: misalign = bus.i_addr_lsb[0];
        3'b010:         misalign = (bus.i_addr_lsb != 2'd0);
        default:        misalign = 1'b0;
      endcase
    end

    // Reserved select 11 falls back to the ALU result.
    case (bus.i_wb_sel)
      2'b01:   wb_data = ld_fmt;
      2'b10:   wb_data = bus.i_pc + 32'd4;
      default: wb_data = bus.i_alu_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      rd_wren_q  <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= '0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (bus.i_flush) begin
      valid_q    <= 1'b0;
      rd_wren_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else if (bus.i_stall) begin
      misalign_q <= 1'b0;
    end else begin
      valid_q    <= bus.i_valid;
      rd_wren_q  <= bus.i_valid && bus.i_rd_wren && (bus.i_rd_addr != 5'd0) && !misalign;
      rd_addr_q  <= bus.i_rd_addr;
      rd_data_q  <= wb_data;
      pc_q       <= bus.i_pc;
      misalign_q <= misalign;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_rd_wren     = rd_wren_q;
  assign bus.o_rd_addr     = rd_addr_q;
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_ld_misalign = misalign_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q <= 64'h0;
    end else if (capture && bus.i_valid && !misalign) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign bus.o_instret = instret_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign bus.o_instret  = 64'h0;
`endif

endmodule
